// File: rtl/redmule_z_tile_buffer_if.sv
// redmule_z_tile_buffer_if: fill and drain handshake bundle of the Z tile buffer
interface redmule_z_tile_buffer_if #(
  parameter int Height = 4,
  parameter int Width  = 8,
  parameter int DATA_W = 16
);
  logic                       fill;
  logic [Height*DATA_W-1:0]   fill_data;
  logic                       store;
  logic                       z_valid;
  logic                       z_ready;
  logic [Width*DATA_W-1:0]    z_data;
  modport master (output fill, fill_data, store, z_ready, input z_valid, z_data);
  modport slave  (input fill, fill_data, store, z_ready, output z_valid, z_data);
endinterface

// File: rtl/redmule_z_tile_buffer.sv
// redmule_z_tile_buffer: collects engine columns, drains the tile transposed as rows
module redmule_z_tile_buffer #(
  parameter int Height = 4,
  parameter int Width  = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     clk_en_i,
  redmule_z_tile_buffer_if.slave   z_if,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o
);
  localparam int CW = Width > 1 ? $clog2(Width) : 1;
  localparam int RW = Height > 1 ? $clog2(Height) : 1;
  localparam logic [0:0] FILL = 1'b0, DRAIN = 1'b1;
  logic [0:0]        r_state;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_act, r_ovf;
  logic [DATA_W-1:0] r_mem [Height][Width];
  logic              w_beat, w_valid, w_hs, w_last_col, w_last_row;
  assign w_beat     = z_if.fill && clk_en_i;
  assign w_valid    = (r_state == DRAIN) && (z_if.store || r_act);
  assign w_hs       = w_valid && z_if.z_ready;
  assign w_last_col = r_col == CW'(Width - 1);
  assign w_last_row = r_row == RW'(Height - 1);
  assign full_o     = r_state == DRAIN;
  assign empty_o    = (r_state == FILL) && (r_col == '0);
  assign ovf_o      = r_ovf;
  assign z_if.z_valid = w_valid;
  for (genvar c = 0; c < Width; c++) begin : g_row
    assign z_if.z_data[c*DATA_W +: DATA_W] = w_valid ? r_mem[r_row][c] : '0;
  end
  // r_act keeps a started row offered until its handshake, independent of store
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= FILL;
      r_col   <= '0;
      r_row   <= '0;
      r_act   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clear_i) begin
      r_state <= FILL;
      r_col   <= '0;
      r_row   <= '0;
      r_act   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == FILL) begin
      if (w_beat) begin
        r_col   <= w_last_col ? '0 : r_col + CW'(1);
        r_state <= w_last_col ? DRAIN : FILL;
      end
    end else begin
      r_act <= w_valid && !w_hs;
      if (w_beat) r_ovf <= 1'b1;
      if (w_hs) begin
        r_row   <= w_last_row ? '0 : r_row + RW'(1);
        r_state <= w_last_row ? FILL : DRAIN;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!clear_i && r_state == FILL && w_beat)
      for (int r = 0; r < Height; r++) r_mem[r][r_col] <= z_if.fill_data[r*DATA_W +: DATA_W];
  end
endmodule

// File: tb/tb_redmule_z_tile_buffer.sv
// tb_redmule_z_tile_buffer: random and directed stimulus against a tile-level reference model
module tb_redmule_z_tile_buffer;
  localparam int H = 4, W = 8, D = 16;
  logic clk_i = 0, rst_i = 0, clear_i = 0, clk_en_i = 1;
  logic full_o, empty_o, ovf_o;
  int n_chk = 0, n_fail = 0;
  redmule_z_tile_buffer_if #(.Height(H), .Width(W), .DATA_W(D)) zif ();
  redmule_z_tile_buffer #(.Height(H), .Width(W), .DATA_W(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .clk_en_i(clk_en_i),
    .z_if(zif), .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o));
  always #5 clk_i = ~clk_i;
  // model: tile contents plus counts of accepted columns and completed rows
  logic [D-1:0] m_tile [H][W];
  int m_cols = 0, m_rows = 0;
  bit m_drain = 0, m_pend = 0, m_ovf = 0;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model_reset();
    m_cols = 0; m_rows = 0; m_drain = 0; m_pend = 0; m_ovf = 0;
  endfunction
  task automatic step();
    logic ev;
    logic [W*D-1:0] ed;
    if (rst_i) model_reset();
    #1;
    ev = m_drain && (zif.store || m_pend);
    ed = '0;
    if (ev) for (int c = 0; c < W; c++) ed[c*D +: D] = m_tile[m_rows][c];
    check("z_valid", 128'(zif.z_valid), 128'(ev));
    check("z_data", 128'(zif.z_data), 128'(ed));
    check("full", 128'(full_o), 128'(m_drain));
    check("empty", 128'(empty_o), 128'(!m_drain && m_cols == 0));
    check("ovf", 128'(ovf_o), 128'(m_ovf));
    @(posedge clk_i);
    if (rst_i || clear_i) model_reset();
    else if (!m_drain) begin
      if (zif.fill && clk_en_i) begin
        for (int r = 0; r < H; r++) m_tile[r][m_cols] = zif.fill_data[r*D +: D];
        m_cols++;
        if (m_cols == W) begin m_cols = 0; m_drain = 1; m_rows = 0; end
      end
    end else begin
      if (zif.fill && clk_en_i) m_ovf = 1;
      if (ev && zif.z_ready) begin
        m_pend = 0;
        m_rows++;
        if (m_rows == H) begin m_rows = 0; m_drain = 0; end
      end else m_pend = ev;
    end
    @(negedge clk_i);
  endtask
  task automatic fill_beats(input int n, input bit pattern);
    for (int k = 0; k < n; k++) begin
      zif.fill = 1;
      for (int r = 0; r < H; r++)
        zif.fill_data[r*D +: D] = pattern ? D'((r << 4) | k) : D'($urandom);
      step();
    end
    zif.fill = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    zif.fill = 0; zif.fill_data = '0; zif.store = 0; zif.z_ready = 0;
    @(negedge clk_i);
    rst_i = 1; step(); rst_i = 0;
    idle(2);
    // patterned tile, streamer always ready
    zif.store = 1; zif.z_ready = 1;
    fill_beats(W, 1);
    idle(6);
    // backpressure: ready toggles each cycle
    zif.store = 0; zif.z_ready = 0;
    fill_beats(W, 0);
    zif.store = 1;
    for (int i = 0; i < 12; i++) begin zif.z_ready = i[0]; step(); end
    // store dropped while a row is pending
    zif.store = 0; zif.z_ready = 0;
    fill_beats(W, 0);
    zif.store = 1; step();
    zif.store = 0; idle(2);
    zif.z_ready = 1; idle(3);
    zif.store = 1; idle(5);
    zif.store = 0;
    // disabled beat ignored
    for (int k = 0; k < W + 1; k++) begin
      clk_en_i = (k != 2);
      zif.fill = 1;
      zif.fill_data = {$urandom, $urandom};
      step();
    end
    zif.fill = 0; clk_en_i = 1;
    // fill pulses during drain set ovf and leave contents alone
    zif.fill = 1; zif.fill_data = {$urandom, $urandom}; step();
    zif.fill = 0; zif.store = 1; zif.z_ready = 0; step();
    zif.fill = 1; zif.fill_data = {$urandom, $urandom}; step();
    zif.fill = 0; zif.z_ready = 1; idle(6);
    // clear mid-fill, reset mid-drain
    zif.store = 0;
    fill_beats(5, 0);
    clear_i = 1; step(); clear_i = 0;
    idle(1);
    fill_beats(W, 0);
    zif.store = 1; idle(2);
    rst_i = 1; step(); rst_i = 0;
    zif.store = 0; idle(1);
    fill_beats(W, 1);
    zif.store = 1; idle(6);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      zif.fill = ($urandom_range(0, 3) != 0);
      clk_en_i = ($urandom_range(0, 7) != 0);
      zif.fill_data = {$urandom, $urandom};
      zif.store = ($urandom_range(0, 2) != 0);
      zif.z_ready = $urandom_range(0, 1);
      clear_i = ($urandom_range(0, 99) == 0);
      step();
    end
    clear_i = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
